mux_rr: RTL and testbench

MUX_RR -- requirements
Module: mux_rr

---
 rtl/mux_rr_pkg.sv | 9 +
 rtl/mux_defs.v | 6 +
 rtl/mux_rr_pick.sv | 31 +++
 rtl/mux_rr.sv | 84 ++++++++
 tb/tb_mux_rr.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_pkg.sv
// Helper functions for the round-robin output multiplexer.
package mux_rr_pkg;

  // Next round-robin start position after a grant at idx, wrapping at limit.
  function automatic int wrap_inc(input int idx, input int limit);
    return (idx + 1 >= limit) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_defs.v
// Mode encodings shared by the mux_rr design files.
`ifndef MUX_DEFS_V
`define MUX_DEFS_V
`define MUX_MODE_FIXED 1'b0
`define MUX_MODE_RR    1'b1
`endif

// File: rtl/mux_rr_pick.sv
// Round-robin search: first valid channel at or after ptr, wrapping to 0.
module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic [CHANNELS-1:0] valid,
  input  logic [SELW-1:0]     ptr,
  output logic [SELW-1:0]     grant,
  output logic                found
);

  localparam logic [SELW:0] CH = (SELW+1)'(CHANNELS);

  logic [SELW:0] idx;

  // Visit ptr, ptr+1, ... modulo CHANNELS; the first hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = {1'b0, ptr} + (SELW+1)'(k);
      if (idx >= CH) idx = idx - CH;
      if (!found && valid[idx[SELW-1:0]]) begin
        grant = idx[SELW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr.sv
// Channel multiplexer with fixed-select or round-robin arbitration feeding a
// single registered output stage with valid/ready handshaking.
`include "mux_defs.v"

module mux_rr
  import mux_rr_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SELW:0] CH = (SELW+1)'(CHANNELS);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] rr_grant;
  logic            rr_found;
  logic [SELW-1:0] grant;
  logic            found;
  logic            ld;
  logic            take;

  rr_pick #(
    .CHANNELS(CHANNELS),
    .SELW    (SELW)
  ) u_pick (
    .valid(in_valid),
    .ptr  (ptr),
    .grant(rr_grant),
    .found(rr_found)
  );

  assign ld   = ~out_valid | out_ready;
  assign take = found & ld & ~reset;

  // Out-of-range selects never grant, so in_valid is only indexed when legal.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (mode == `MUX_MODE_RR) begin
      grant = rr_grant;
      found = rr_found;
    end else if ({1'b0, sel} < CH) begin
      grant = sel;
      found = in_valid[sel];
    end
  end

  always_comb begin
    in_ready = '0;
    if (take) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (ld) begin
      if (found) begin
        out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
        out_chan  <= grant;
        out_valid <= 1'b1;
        if (mode == `MUX_MODE_RR) ptr <= SELW'(wrap_inc(int'(grant), CHANNELS));
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr.sv
// Self-checking bench for mux_rr (WIDTH=16, CHANNELS=4) using a scoreboard queue.
module tb_mux_rr;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  int          passed;
  int          total;
  int          m_ptr;
  logic [17:0] sb[$];

  mux_rr #(.WIDTH(16), .CHANNELS(4), .SELW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbiter: first valid channel scanning upward from p.
  function automatic int exp_rr(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int g);
    if (g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  task automatic test_reset();
    reset = 1'b1; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111; in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
      total++; if (out_data !== 16'h0000) $display("[TB] FAIL reset_out_data: got %h expected 0000", out_data); else passed++;
      total++; if (in_ready !== 4'b0000) $display("[TB] FAIL reset_in_ready: got %b expected 0000", in_ready); else passed++;
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 4'b0000;
    m_ptr = 0;
    sb.delete();
  endtask

  task automatic test_fixed();
    logic [17:0] e;
    @(negedge clk);
    mode = 1'b0; sel = 2'd2; out_ready = 1'b1; in_valid = 4'b1111;
    in_data = {16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    #2;
    total++; if (in_ready !== 4'b0100) $display("[TB] FAIL fixed_in_ready: got %b expected 0100", in_ready); else passed++;
    sb.push_back({2'd2, 16'hBEEF});
    @(negedge clk);
    in_valid = 4'b0000;
    #2;
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL fixed_out_valid: got %b expected 1", out_valid); else passed++;
    if (out_valid === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      total++; if (out_chan !== e[17:16]) $display("[TB] FAIL fixed_out_chan: got %0d expected %0d", out_chan, e[17:16]); else passed++;
      total++; if (out_data !== e[15:0]) $display("[TB] FAIL fixed_out_data: got %h expected %h", out_data, e[15:0]); else passed++;
    end
    @(negedge clk); #2;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL fixed_drained: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_rr_fairness();
    logic [17:0] e;
    int g;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      mode = 1'b1; out_ready = 1'b1;
      in_valid = (c < 8) ? 4'b1111 : 4'b0000;
      in_data = {16'hC300 | 16'(c), 16'hC200 | 16'(c), 16'hC100 | 16'(c), 16'hC000 | 16'(c)};
      #2;
      total++; if (out_valid !== (sb.size() != 0)) $display("[TB] FAIL rr_no_bubble c=%0d: got %b expected %b", c, out_valid, sb.size() != 0); else passed++;
      if (out_valid === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        total++; if (out_chan !== e[17:16]) $display("[TB] FAIL rr_out_chan c=%0d: got %0d expected %0d", c, out_chan, e[17:16]); else passed++;
        total++; if (out_data !== e[15:0]) $display("[TB] FAIL rr_out_data c=%0d: got %h expected %h", c, out_data, e[15:0]); else passed++;
      end
      g = exp_rr(in_valid, m_ptr);
      total++; if (in_ready !== onehot(g)) $display("[TB] FAIL rr_in_ready c=%0d: got %b expected %b", c, in_ready, onehot(g)); else passed++;
      if (g >= 0) begin
        sb.push_back({2'(g), in_data[g*16 +: 16]});
        m_ptr = (g + 1) % 4;
      end
    end
    @(negedge clk); #2;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL rr_drained: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_skip_wrap();
    logic [3:0] table_v[5] = '{4'b0100, 4'b0010, 4'b1111, 4'b0000, 4'b0000};
    logic [17:0] e;
    int g;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mode = 1'b1; out_ready = 1'b1; in_valid = table_v[c];
      in_data = {16'hD300 | 16'(c), 16'hD200 | 16'(c), 16'hD100 | 16'(c), 16'hD000 | 16'(c)};
      #2;
      total++; if (out_valid !== (sb.size() != 0)) $display("[TB] FAIL skip_out_valid c=%0d: got %b expected %b", c, out_valid, sb.size() != 0); else passed++;
      if (out_valid === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        total++; if (out_chan !== e[17:16]) $display("[TB] FAIL skip_out_chan c=%0d: got %0d expected %0d", c, out_chan, e[17:16]); else passed++;
        total++; if (out_data !== e[15:0]) $display("[TB] FAIL skip_out_data c=%0d: got %h expected %h", c, out_data, e[15:0]); else passed++;
      end
      g = exp_rr(in_valid, m_ptr);
      total++; if (in_ready !== onehot(g)) $display("[TB] FAIL skip_in_ready c=%0d: got %b expected %b", c, in_ready, onehot(g)); else passed++;
      if (g >= 0) begin
        sb.push_back({2'(g), in_data[g*16 +: 16]});
        m_ptr = (g + 1) % 4;
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [17:0] e;
    @(negedge clk);
    mode = 1'b0; sel = 2'd1; out_ready = 1'b1; in_valid = 4'b0010;
    in_data = {16'h0004, 16'h0003, 16'h1234, 16'h0001};
    #2;
    total++; if (in_ready !== 4'b0010) $display("[TB] FAIL bp_load_in_ready: got %b expected 0010", in_ready); else passed++;
    sb.push_back({2'd1, 16'h1234});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 4'b1111;
      in_data = {16'h5555, 16'h5555, 16'h5555, 16'h5555};
      #2;
      total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid i=%0d: got %b expected 1", i, out_valid); else passed++;
      total++; if (out_data !== 16'h1234) $display("[TB] FAIL bp_hold_data i=%0d: got %h expected 1234", i, out_data); else passed++;
      total++; if (in_ready !== 4'b0000) $display("[TB] FAIL bp_hold_in_ready i=%0d: got %b expected 0000", i, in_ready); else passed++;
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 4'b0000;
    #2;
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_release_valid: got %b expected 1", out_valid); else passed++;
    if (out_valid === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      total++; if (out_chan !== e[17:16]) $display("[TB] FAIL bp_out_chan: got %0d expected %0d", out_chan, e[17:16]); else passed++;
      total++; if (out_data !== e[15:0]) $display("[TB] FAIL bp_out_data: got %h expected %h", out_data, e[15:0]); else passed++;
    end
    @(negedge clk); #2;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_transfer_once: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_mid_reset();
    logic [17:0] e;
    @(negedge clk);
    mode = 1'b0; sel = 2'd0; out_ready = 1'b0; in_valid = 4'b0001;
    in_data = {16'h0000, 16'h0000, 16'h0000, 16'hAAAA};
    #2;
    total++; if (in_ready !== 4'b0001) $display("[TB] FAIL mr_load_in_ready: got %b expected 0001", in_ready); else passed++;
    sb.push_back({2'd0, 16'hAAAA});
    @(negedge clk);
    in_valid = 4'b0000;
    #2;
    total++; if (out_valid !== 1'b1 || out_data !== 16'hAAAA) $display("[TB] FAIL mr_pending: got %b/%h expected 1/aaaa", out_valid, out_data); else passed++;
    @(negedge clk);
    reset = 1'b1; mode = 1'b1; in_valid = 4'b1111;
    #2;
    total++; if (in_ready !== 4'b0000) $display("[TB] FAIL mr_reset_in_ready: got %b expected 0000", in_ready); else passed++;
    sb.delete();
    m_ptr = 0;
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    in_data = {16'hE003, 16'hE002, 16'hE001, 16'hE000};
    #2;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL mr_discard_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_data !== 16'h0000) $display("[TB] FAIL mr_discard_data: got %h expected 0000", out_data); else passed++;
    total++; if (in_ready !== onehot(exp_rr(in_valid, m_ptr))) $display("[TB] FAIL mr_ptr_cleared: got %b expected %b", in_ready, onehot(exp_rr(in_valid, m_ptr))); else passed++;
    sb.push_back({2'd0, 16'hE000});
    @(negedge clk);
    in_valid = 4'b0000;
    #2;
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL mr_after_valid: got %b expected 1", out_valid); else passed++;
    if (out_valid === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      total++; if (out_chan !== e[17:16]) $display("[TB] FAIL mr_after_chan: got %0d expected %0d", out_chan, e[17:16]); else passed++;
      total++; if (out_data !== e[15:0]) $display("[TB] FAIL mr_after_data: got %h expected %h", out_data, e[15:0]); else passed++;
    end
    @(negedge clk); #2;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL mr_drained: got %b expected 0", out_valid); else passed++;
  endtask

  initial begin
    passed = 0; total = 0; m_ptr = 0;
    reset = 1'b1; mode = 1'b0; sel = 2'd0; in_data = '0; in_valid = 4'b0000; out_ready = 1'b0;
    test_reset();
    test_fixed();
    test_rr_fairness();
    test_skip_wrap();
    test_back_pressure();
    test_mid_reset();
    total++; if (sb.size() != 0) $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
